// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Groups the program-counter stage's control inputs, the Increment block
//   return path and the status/fetch outputs into one bundle.
//   master : the environment (control source, Increment block, fetch side).
//   slave  : the pc_sequencer itself.
//   Signals:
//     Stall/Jump/Call/Ret/Branch  control strobes into the sequencer
//     JumpAddr, Offset            absolute target / signed branch offset
//     IncOut, IncCarry            result of the external Increment block
//     Pc, IncSw                   current PC and Increment enable
//     FetchValid                  Pc is a valid fetch address this cycle
//     Wrapped, StackErr           sticky status flags
//     StackFull, StackEmpty       return-address stack occupancy
interface pc_sequencer_if #(
  parameter int width = 16
);
  logic             Stall;
  logic             Jump;
  logic             Call;
  logic             Ret;
  logic             Branch;
  logic [width-1:0] JumpAddr;
  logic [width-1:0] Offset;
  logic [width-1:0] IncOut;
  logic             IncCarry;
  logic [width-1:0] Pc;
  logic             IncSw;
  logic             FetchValid;
  logic             Wrapped;
  logic             StackFull;
  logic             StackEmpty;
  logic             StackErr;

  modport master (
    output Stall, Jump, Call, Ret, Branch, JumpAddr, Offset, IncOut, IncCarry,
    input  Pc, IncSw, FetchValid, Wrapped, StackFull, StackEmpty, StackErr
  );

  modport slave (
    input  Stall, Jump, Call, Ret, Branch, JumpAddr, Offset, IncOut, IncCarry,
    output Pc, IncSw, FetchValid, Wrapped, StackFull, StackEmpty, StackErr
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter stage. Picks the next PC from the sequential (external
//   Increment block), branch, jump, call or return source and keeps a small
//   LIFO of return addresses.
//   Ports:
//     Clk   single rising-edge clock
//     RstN  synchronous active-low reset
//     bus   pc_sequencer_if slave modport (controls in, PC and status out)
//   Parameters:
//     width         PC width in bits
//     depth         return-address stack entries (power of 2, >= 2)
//     reset_vector  PC loaded on reset
module pc_sequencer #(
  parameter int               width        = 16,
  parameter int               depth        = 4,
  parameter logic [width-1:0] reset_vector = '0
) (
  input logic           Clk,
  input logic           RstN,
  pc_sequencer_if.slave bus
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);
  localparam logic [cw-1:0] full_count = cw'(depth);
  localparam logic [cw-1:0] one_count  = cw'(1);

  logic [width-1:0] pc_q, pc_d;
  logic [cw-1:0]    count_q, count_d;
  logic             started_q;
  logic             wrapped_q, wrapped_d;
  logic             err_q, err_d;
  logic [width-1:0] stack_q [depth];
  logic             push_en;
  logic [aw-1:0]    push_idx;
  logic [aw-1:0]    top_idx;
  logic             stack_empty;
  logic             stack_full;

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == full_count);
  // Next free slot is count itself; top of stack sits one below it.
  assign push_idx    = count_q[aw-1:0];
  assign top_idx     = aw'(count_q - one_count);

  // Next-PC selection, highest priority first: stall, return, call, jump,
  // branch, sequential. Ret always wins over Call, so push and pop never
  // happen together.
  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    err_d     = err_q;
    push_en   = 1'b0;
    if (!bus.Stall) begin
      if (bus.Ret) begin
        if (bus.Call) begin
          err_d = 1'b1;
        end
        if (!stack_empty) begin
          pc_d    = stack_q[top_idx];
          count_d = count_q - one_count;
        end else begin
          // Underflow behaves like a sequential advance, including wrap.
          pc_d  = bus.IncOut;
          err_d = 1'b1;
          if (bus.IncCarry) begin
            wrapped_d = 1'b1;
          end
        end
      end else if (bus.Call) begin
        pc_d = bus.JumpAddr;
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push_en = 1'b1;
          count_d = count_q + one_count;
        end
      end else if (bus.Jump) begin
        pc_d = bus.JumpAddr;
      end else if (bus.Branch) begin
        // Width-bit add; a branch wrap is intentionally not flagged.
        pc_d = pc_q + bus.Offset;
      end else begin
        pc_d = bus.IncOut;
        if (bus.IncCarry) begin
          wrapped_d = 1'b1;
        end
      end
    end
  end

  // Control state; started_q marks the first post-reset cycle as not yet
  // fetch-valid.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      pc_q      <= reset_vector;
      count_q   <= '0;
      started_q <= 1'b0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      count_q   <= count_d;
      started_q <= 1'b1;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
    end
  end

  // Stack storage needs no reset; only count decides which entries are live.
  always_ff @(posedge Clk) begin
    if (RstN && push_en) begin
      stack_q[push_idx] <= bus.IncOut;
    end
  end

  assign bus.Pc         = pc_q;
  assign bus.IncSw      = ~bus.Stall;
  assign bus.FetchValid = started_q & ~bus.Stall;
  assign bus.Wrapped    = wrapped_q;
  assign bus.StackFull  = stack_full;
  assign bus.StackEmpty = stack_empty;
  assign bus.StackErr   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Drives pc_sequencer with directed scenarios followed by random control
//   traffic. A behavioural model (integer PC, queue-based stack) predicts
//   what the outputs should show each cycle; predictions go into a queue and
//   an independent monitor pops and compares them on the falling edge.
//   The external Increment block is modelled with continuous assignments.
module tb_pc_sequencer;

  localparam int W = 16;
  localparam int D = 4;

  logic Clk = 1'b0;
  logic RstN;

  pc_sequencer_if #(.width(W)) bus ();

  pc_sequencer #(
    .width(W),
    .depth(D),
    .reset_vector(16'h0000)
  ) dut (
    .Clk(Clk),
    .RstN(RstN),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Increment block: passes Pc through when disabled.
  assign bus.IncOut   = bus.IncSw ? bus.Pc + 16'd1 : bus.Pc;
  assign bus.IncCarry = bus.IncSw && (bus.Pc == 16'hFFFF);

  typedef struct {
    int pc;
    bit fv;
    bit inc_sw;
    bit wrapped;
    bit full;
    bit empty;
    bit err;
  } obs_t;

  obs_t exp_q[$];

  // Reference model state.
  int m_pc;
  int m_stack[$];
  bit m_wrapped;
  bit m_err;
  int m_cycles;

  int assert_count = 0;
  int fail_count   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time,
               actual, expected);
    end
  endtask

  // Model of one rising edge, written from the architectural rules.
  task automatic modelEdge(input bit r, input bit st, input bit j,
                           input bit c, input bit rt, input bit b,
                           input logic [15:0] ja, input logic [15:0] off);
    if (!r) begin
      m_pc      = 0;
      m_stack.delete();
      m_wrapped = 0;
      m_err     = 0;
      m_cycles  = 0;
      return;
    end
    m_cycles++;
    if (st) return;
    if (rt) begin
      if (c) m_err = 1;
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
      end else begin
        m_err = 1;
        if (m_pc == 65535) m_wrapped = 1;
        m_pc = (m_pc + 1) % 65536;
      end
    end else if (c) begin
      if (m_stack.size() < D) m_stack.push_back((m_pc + 1) % 65536);
      else m_err = 1;
      m_pc = int'(ja);
    end else if (j) begin
      m_pc = int'(ja);
    end else if (b) begin
      m_pc = (m_pc + int'(off)) % 65536;
    end else begin
      if (m_pc == 65535) m_wrapped = 1;
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  // Drives one cycle's inputs, records what the outputs should show in that
  // cycle, then advances the model across the coming edge.
  task automatic applyStimulus(input bit r, input bit st, input bit j,
                               input bit c, input bit rt, input bit b,
                               input logic [15:0] ja, input logic [15:0] off);
    obs_t o;
    #2;
    RstN         = r;
    bus.Stall    = st;
    bus.Jump     = j;
    bus.Call     = c;
    bus.Ret      = rt;
    bus.Branch   = b;
    bus.JumpAddr = ja;
    bus.Offset   = off;
    o.pc      = m_pc;
    o.fv      = (m_cycles >= 1) && !st;
    o.inc_sw  = !st;
    o.wrapped = m_wrapped;
    o.full    = (m_stack.size() == D);
    o.empty   = (m_stack.size() == 0);
    o.err     = m_err;
    exp_q.push_back(o);
    modelEdge(r, st, j, c, rt, b, ja, off);
    @(posedge Clk);
  endtask

  task automatic seqCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic resetCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic jumpTo(input logic [15:0] a);
    applyStimulus(1, 0, 1, 0, 0, 0, a, 16'h0);
  endtask

  task automatic callTo(input logic [15:0] a);
    applyStimulus(1, 0, 0, 1, 0, 0, a, 16'h0);
  endtask

  task automatic doRet();
    applyStimulus(1, 0, 0, 0, 1, 0, 16'h0, 16'h0);
  endtask

  // Monitor: compares every predicted observation against the DUT outputs
  // half a cycle after the inputs settle.
  initial begin
    obs_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("Pc",         32'(bus.Pc),         32'(e.pc));
        checkOutput("FetchValid", 32'(bus.FetchValid), 32'(e.fv));
        checkOutput("IncSw",      32'(bus.IncSw),      32'(e.inc_sw));
        checkOutput("Wrapped",    32'(bus.Wrapped),    32'(e.wrapped));
        checkOutput("StackFull",  32'(bus.StackFull),  32'(e.full));
        checkOutput("StackEmpty", 32'(bus.StackEmpty), 32'(e.empty));
        checkOutput("StackErr",   32'(bus.StackErr),   32'(e.err));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit r, st, j, c, rt, b;
    logic [15:0] ja, off;

    RstN         = 1'b0;
    bus.Stall    = 1'b0;
    bus.Jump     = 1'b0;
    bus.Call     = 1'b0;
    bus.Ret      = 1'b0;
    bus.Branch   = 1'b0;
    bus.JumpAddr = '0;
    bus.Offset   = '0;
    @(posedge Clk);
    modelEdge(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);

    // Reset then free-run.
    resetCycle();
    seqCycles(4);

    // Stall holds PC despite a pending jump.
    jumpTo(16'h0005);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 0, 16'h1234, 16'h0);
    seqCycles(2);

    // Branches, including a wrapping one that must not set Wrapped.
    jumpTo(16'h0010);
    applyStimulus(1, 0, 0, 0, 0, 1, 16'h0, 16'hFFFC);
    jumpTo(16'hFFFE);
    applyStimulus(1, 0, 0, 0, 0, 1, 16'h0, 16'h0004);
    seqCycles(1);

    // Nested call/return.
    resetCycle();
    jumpTo(16'h0100);
    callTo(16'h0200);
    seqCycles(3);
    callTo(16'h0300);
    doRet();
    doRet();
    seqCycles(1);

    // Overflow: five calls into a four-entry stack.
    for (int i = 0; i < 5; i++) callTo(16'(16'h0400 + 16'(i * 16)));
    seqCycles(1);

    // Underflow from an empty stack.
    resetCycle();
    jumpTo(16'h0007);
    doRet();
    seqCycles(1);

    // Call together with Ret pops and flags an error.
    resetCycle();
    jumpTo(16'h004F);
    callTo(16'h0060);
    applyStimulus(1, 0, 0, 1, 1, 0, 16'h0070, 16'h0);
    seqCycles(1);

    // Sequential wrap is sticky across jumps until reset.
    resetCycle();
    jumpTo(16'hFFFF);
    seqCycles(2);
    jumpTo(16'h1000);
    jumpTo(16'h0002);
    resetCycle();
    seqCycles(2);

    // Ret on empty at all-ones also counts as a sequential wrap.
    jumpTo(16'hFFFF);
    doRet();
    seqCycles(1);
    resetCycle();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      r   = ($urandom_range(0, 59) != 0);
      st  = ($urandom_range(0, 5) == 0);
      rt  = ($urandom_range(0, 5) == 0);
      c   = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 7) == 0);
      b   = ($urandom_range(0, 3) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                        : 16'($urandom);
      off = 16'($urandom);
      applyStimulus(r, st, j, c, rt, b, ja, off);
    end

    @(negedge Clk);
    #1;
    checkOutput("PendingChecks", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
